// File: rtl/phy_pkg.sv
// Shared PHY definitions used by phy_tx and phy_rx: sync symbol, frame length, frame class.
package phy_pkg;

    localparam logic [7:0]  COM_SYMBOL = 8'hBC;
    localparam int unsigned FRAME_LEN  = 16;
    localparam int unsigned CNT_W      = $clog2(FRAME_LEN);

    // Content class of the frame currently on the lanes
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        DATA = 2'd2
    } phy_state_e;

endpackage

// File: rtl/phy_tx_serializer.sv
// One lane serializer: 8-bit parallel-load shift register, MSB shifted out first.
module phy_tx_serializer (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       dout
);

    logic [7:0] sr;

    // Load a new byte or shift toward the MSB; load wins over shift
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[6:0], 1'b0};
        end
    end

    assign dout = sr[7];

endmodule

// File: rtl/phy_tx.sv
// Two-lane PHY transmitter: COM sync preamble, then IDLE/DATA frames of 16 bits per lane.
// Optional feature: define PHY_TX_LANE_SKEW_EN to delay lane 1 by 4 cycles.
module phy_tx #(
    parameter logic [7:0]  COM_SYMBOL  = phy_pkg::COM_SYMBOL,
    parameter int unsigned SYNC_FRAMES = 2
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready,
    output logic        data_out_0,
    output logic        data_out_1,
    output logic        active
);

    import phy_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] SLOT_B_CNT = CNT_W'(FRAME_LEN / 2);
    localparam logic [3:0]       SYNC_DONE  = 4'(SYNC_FRAMES);

    phy_state_e       state;
    logic [CNT_W-1:0] cnt;        // position of the bit emitted at the next edge
    logic [3:0]       sync_cnt;   // completed SYNC frames
    logic [15:0]      word_lo;    // slot B bytes of the word in flight

    logic       frame_start_c;
    logic       slot_b_c;
    logic       load_c;
    logic       capture_c;
    logic [7:0] byte0_c;
    logic [7:0] byte1_c;
    logic       lane0_bit;
    logic       lane1_bit;

    // Byte selection for each lane at slot boundaries
    always_comb begin
        frame_start_c = (cnt == '0);
        slot_b_c      = (cnt == SLOT_B_CNT);
        load_c        = frame_start_c || slot_b_c;
        capture_c     = ready && valid_in;
        byte0_c       = COM_SYMBOL;
        byte1_c       = COM_SYMBOL;
        if (frame_start_c && capture_c) begin
            byte0_c = data_in[31:24];
            byte1_c = data_in[23:16];
        end else if (slot_b_c && (state == DATA)) begin
            byte0_c = word_lo[15:8];
            byte1_c = word_lo[7:0];
        end
    end

    // Frame counter, preamble tracking and frame-class FSM with registered ready/active
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state    <= SYNC;
            cnt      <= '0;
            sync_cnt <= '0;
            word_lo  <= '0;
            ready    <= 1'b0;
            active   <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            ready <= (cnt == LAST_CNT) && (state != SYNC);
            if ((cnt == LAST_CNT) && (state == SYNC) && (sync_cnt != SYNC_DONE)) begin
                sync_cnt <= sync_cnt + 4'd1;
            end
            if (frame_start_c && ((state != SYNC) || (sync_cnt == SYNC_DONE))) begin
                active <= 1'b1;
                state  <= capture_c ? DATA : IDLE;
                if (capture_c) begin
                    word_lo <= data_in[15:0];
                end
            end
        end
    end

    phy_tx_serializer u_ser_lane0 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .load    (load_c),
        .shift   (!load_c),
        .din     (byte0_c),
        .dout    (lane0_bit)
    );

    phy_tx_serializer u_ser_lane1 (
        .clk_32f (clk_32f),
        .reset   (reset),
        .load    (load_c),
        .shift   (!load_c),
        .din     (byte1_c),
        .dout    (lane1_bit)
    );

    assign data_out_0 = lane0_bit;

`ifdef PHY_TX_LANE_SKEW_EN
    logic [3:0] skew_sr;

    // Four-cycle delay line on lane 1 to emulate inter-lane skew
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            skew_sr <= '0;
        end else begin
            skew_sr <= {skew_sr[2:0], lane1_bit};
        end
    end

    assign data_out_1 = skew_sr[3];
`else
    assign data_out_1 = lane1_bit;
`endif

endmodule

// File: tb/tb_phy_tx.sv
// Self-checking bench for phy_tx against a frame-level reference model.
module tb_phy_tx;

    localparam int         SF  = 2;
    localparam logic [7:0] COM = 8'hBC;

    logic        clk_32f;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready;
    logic        data_out_0;
    logic        data_out_1;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          k = -1;
    bit          cur_data;
    logic [31:0] cur_word;
    logic        lane1_hist[$];
    logic        exp_d0, exp_d1, exp_rdy, exp_act;

    phy_tx #(.COM_SYMBOL(COM), .SYNC_FRAMES(SF)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready      (ready),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .active     (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    // Expected outputs after the coming edge, from the frame-level rules
    task automatic model_edge(input logic rst_v, input logic v, input logic [31:0] d);
        int pos, frame, bi;
        logic [7:0] b0, b1;
        logic l1;
        if (!rst_v) begin
            k = -1;
            cur_data = 0;
            lane1_hist.delete();
            exp_d0 = 0; exp_d1 = 0; exp_rdy = 0; exp_act = 0;
            return;
        end
        k++;
        pos   = k % 16;
        frame = k / 16;
        if (pos == 0) begin
            if (frame - 1 >= SF) begin
                cur_data = v;
                if (v) cur_word = d;
            end else begin
                cur_data = 0;
            end
        end
        if (frame < SF || !cur_data) begin
            b0 = COM; b1 = COM;
        end else if (pos < 8) begin
            b0 = cur_word[31:24]; b1 = cur_word[23:16];
        end else begin
            b0 = cur_word[15:8];  b1 = cur_word[7:0];
        end
        bi = 7 - (pos % 8);
        exp_d0 = b0[bi];
        l1     = b1[bi];
        lane1_hist.push_back(l1);
`ifdef PHY_TX_LANE_SKEW_EN
        exp_d1 = (k >= 4) ? lane1_hist[k - 4] : 1'b0;
`else
        exp_d1 = l1;
`endif
        exp_rdy = (frame >= SF) && (pos == 15);
        exp_act = (frame >= SF);
    endtask

    task automatic clk_cycle();
        model_edge(reset, valid_in, data_in);
        @(posedge clk_32f);
        #1;
    endtask

    task automatic test_reset();
        reset = 0; valid_in = 0; data_in = '0;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset cyc %0d got %b exp 0000", i, {data_out_0, data_out_1, ready, active});
            end
        end
    endtask

    task automatic test_sync_preamble();
        logic [31:0] c0;
        int first_rdy, first_act;
        c0 = '0; first_rdy = -1; first_act = -1;
        reset = 1; valid_in = 0;
        for (int i = 0; i < 48; i++) begin
            data_in = $urandom;
            clk_cycle();
            if (i < 32) c0 = {c0[30:0], data_out_0};
            if (ready  === 1'b1 && first_rdy < 0) first_rdy = i;
            if (active === 1'b1 && first_act < 0) first_act = i;
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== {exp_d0, exp_d1, exp_rdy, exp_act}) begin
                n_fail++;
                $display("FAIL sync k=%0d got %b exp %b", k, {data_out_0, data_out_1, ready, active},
                         {exp_d0, exp_d1, exp_rdy, exp_act});
            end
        end
        n_checks++;
        if (c0 !== {4{COM}}) begin
            n_fail++;
            $display("FAIL sync_lane0 got %h exp %h", c0, {4{COM}});
        end
        n_checks++;
        if (first_act != 32) begin
            n_fail++;
            $display("FAIL active_rise got %0d exp 32", first_act);
        end
        n_checks++;
        if (first_rdy != 47) begin
            n_fail++;
            $display("FAIL first_ready got %0d exp 47", first_rdy);
        end
    endtask

    // Entered while sitting in a ready (count 15) cycle
    task automatic test_single_word();
        logic [15:0] c0, c1, i0, i1;
        c0 = '0; c1 = '0; i0 = '0; i1 = '0;
        valid_in = 1; data_in = 32'hAA556633;
        for (int i = 0; i < 32; i++) begin
            clk_cycle();
            if (i < 16) begin
                c0 = {c0[14:0], data_out_0}; c1 = {c1[14:0], data_out_1};
            end else begin
                i0 = {i0[14:0], data_out_0}; i1 = {i1[14:0], data_out_1};
            end
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== {exp_d0, exp_d1, exp_rdy, exp_act}) begin
                n_fail++;
                $display("FAIL single k=%0d got %b exp %b", k, {data_out_0, data_out_1, ready, active},
                         {exp_d0, exp_d1, exp_rdy, exp_act});
            end
            data_in  = $urandom;
            valid_in = (k % 16 == 15) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        n_checks++;
        if (c0 !== 16'hAA66) begin
            n_fail++;
            $display("FAIL single_lane0 got %h exp aa66", c0);
        end
        n_checks++;
        if (i0 !== {2{COM}}) begin
            n_fail++;
            $display("FAIL idle_lane0 got %h exp %h", i0, {2{COM}});
        end
`ifndef PHY_TX_LANE_SKEW_EN
        n_checks++;
        if (c1 !== 16'h5533) begin
            n_fail++;
            $display("FAIL single_lane1 got %h exp 5533", c1);
        end
        n_checks++;
        if (i1 !== {2{COM}}) begin
            n_fail++;
            $display("FAIL idle_lane1 got %h exp %h", i1, {2{COM}});
        end
`endif
    endtask

    // Entered while sitting in a ready (count 15) cycle
    task automatic test_back_to_back();
        logic [31:0] c0, c1;
        int n_rdy;
        c0 = '0; c1 = '0; n_rdy = 0;
        valid_in = 1; data_in = 32'h12345678;
        for (int i = 0; i < 32; i++) begin
            clk_cycle();
            c0 = {c0[30:0], data_out_0}; c1 = {c1[30:0], data_out_1};
            if (ready === 1'b1) n_rdy++;
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== {exp_d0, exp_d1, exp_rdy, exp_act}) begin
                n_fail++;
                $display("FAIL b2b k=%0d got %b exp %b", k, {data_out_0, data_out_1, ready, active},
                         {exp_d0, exp_d1, exp_rdy, exp_act});
            end
            if (i == 0) data_in = 32'hDEADBEEF;
            if (i == 16) valid_in = 0;
        end
        n_checks++;
        if (c0 !== 32'h1256DEBE) begin
            n_fail++;
            $display("FAIL b2b_lane0 got %h exp 1256debe", c0);
        end
        n_checks++;
        if (n_rdy != 2) begin
            n_fail++;
            $display("FAIL b2b_ready_count got %0d exp 2", n_rdy);
        end
`ifndef PHY_TX_LANE_SKEW_EN
        n_checks++;
        if (c1 !== 32'h3478ADEF) begin
            n_fail++;
            $display("FAIL b2b_lane1 got %h exp 3478adef", c1);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = $urandom;
            clk_cycle();
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== {exp_d0, exp_d1, exp_rdy, exp_act}) begin
                n_fail++;
                $display("FAIL random k=%0d got %b exp %b", k, {data_out_0, data_out_1, ready, active},
                         {exp_d0, exp_d1, exp_rdy, exp_act});
            end
        end
    endtask

    task automatic test_midframe_reset();
        int first_act;
        logic first_bit;
        first_act = -1;
        valid_in = 0;
        for (int i = 0; i < 16 && (k % 16) != 15; i++) clk_cycle();
        valid_in = 1; data_in = $urandom;
        clk_cycle();
        valid_in = 0;
        for (int i = 0; i < 5; i++) clk_cycle();
        n_checks++;
        if (k % 16 != 5) begin
            n_fail++;
            $display("FAIL midreset_align got %0d exp 5", k % 16);
        end
        reset = 0;
        clk_cycle();
        n_checks++;
        if ({data_out_0, data_out_1, ready, active} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_zero got %b exp 0000", {data_out_0, data_out_1, ready, active});
        end
        reset = 1;
        first_bit = 1'b0;
        for (int i = 0; i < 16 * SF + 16; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = $urandom;
            clk_cycle();
            if (i == 0) first_bit = data_out_0;
            if (active === 1'b1 && first_act < 0) first_act = i;
            n_checks++;
            if ({data_out_0, data_out_1, ready, active} !== {exp_d0, exp_d1, exp_rdy, exp_act}) begin
                n_fail++;
                $display("FAIL restart k=%0d got %b exp %b", k, {data_out_0, data_out_1, ready, active},
                         {exp_d0, exp_d1, exp_rdy, exp_act});
            end
        end
        n_checks++;
        if (first_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_first_bit got %b exp 1", first_bit);
        end
        n_checks++;
        if (first_act != 16 * SF) begin
            n_fail++;
            $display("FAIL restart_active got %0d exp %0d", first_act, 16 * SF);
        end
    endtask

    initial begin
        reset = 0; valid_in = 0; data_in = '0;
        test_reset();
        test_sync_preamble();
        test_single_word();
        test_back_to_back();
        test_random();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_tx.md
PHY_TX -- requirements
Module: phy_tx

Interface
REQ-001 SHALL have parameter COM_SYMBOL, default 8'hBC, the sync/idle symbol sent on each lane.
REQ-002 SHALL have parameter SYNC_FRAMES, default 2, the number of COM frames sent after reset before data is accepted (range 1..15).
REQ-003 SHALL have port clk_32f, input, 1 bit: the single bit-rate clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 32 bits: parallel word to transmit.
REQ-006 SHALL have port valid_in, input, 1 bit: data_in holds a word to send.
REQ-007 SHALL have port ready, output, 1 bit: the block accepts data_in on this cycle.
REQ-008 SHALL have port data_out_0, output, 1 bit: serial lane 0.
REQ-009 SHALL have port data_out_1, output, 1 bit: serial lane 1.
REQ-010 SHALL have port active, output, 1 bit: sync preamble complete, data path live.

Function
REQ-011 SHALL run a 4-bit frame counter, 0..15, wrapping 15->0; one frame is 16 cycles and carries 2 bytes per lane (slot A = counts 0-7, slot B = counts 8-15).
REQ-012 SHALL send each byte MSB first, one bit per clk_32f cycle.
REQ-013 SHALL stripe each data word as: lane 0 slot A = data_in[31:24], lane 1 slot A = [23:16], lane 0 slot B = [15:8], lane 1 slot B = [7:0].
REQ-014 SHALL implement states SYNC, IDLE and DATA, where the state is the content class of the current frame.
REQ-015 SHALL, in SYNC, send COM_SYMBOL in both slots on both lanes, with ready=0 and active=0.
REQ-016 SHALL leave SYNC for IDLE at the frame boundary (count 15->0) after SYNC_FRAMES complete frames.
REQ-017 SHALL assert ready only in IDLE or DATA, only at count 15.
REQ-018 SHALL capture data_in on the cycle where valid_in && ready, and start the next frame in DATA with that word; bit 31 appears on data_out_0 one cycle after capture.
REQ-019 SHALL, when valid_in=0 at count 15, make the next frame IDLE: COM_SYMBOL on both lanes in both slots.
REQ-020 SHALL hold active=1 in IDLE and DATA; back-to-back valid words give back-to-back DATA frames with no gap.
REQ-021 SHALL ignore valid_in whenever ready=0; data_in changes outside the capture cycle SHALL NOT affect the frame in flight.

Reset
REQ-022 SHALL, with reset=0 at a rising edge, force state=SYNC, frame counter=0, SYNC frame count=0, data_out_0=0, data_out_1=0, ready=0 and active=0 on that edge.
REQ-023 SHALL abort any frame in flight when reset is asserted mid-frame; a word that was captured but not yet fully sent is discarded.
REQ-024 SHALL start the first COM bit (1) on both lanes in the first cycle after reset returns to 1.

Configuration
REQ-025 SHALL, with macro PHY_TX_LANE_SKEW_EN defined, delay data_out_1 by exactly 4 clk_32f cycles through a 4-stage shift register reset to 0, to emulate lane-to-lane skew for the receiver deskew logic.
REQ-026 SHALL, without PHY_TX_LANE_SKEW_EN, drive both lanes bit-aligned with zero extra delay.

Structure
REQ-027 SHALL take COM_SYMBOL, the frame length constant (16) and the state enum {SYNC, IDLE, DATA} from shared package phy_pkg, which phy_rx also uses.
REQ-028 SHALL instantiate sub-module phy_tx_serializer twice, one per lane: an 8-bit parallel-load shift register with load and shift enables.

Verification
REQ-029 SHALL check reset held low for 5 cycles -> data_out_0=data_out_1=0, ready=0, active=0 on every cycle.
REQ-030 SHALL check reset release, valid_in=0 -> each lane repeats 1,0,1,1,1,1,0,0 for 32 cycles; active rises at cycle 32 and ready first pulses at cycle 47.
REQ-031 SHALL check data_in=32'hAA556633 captured -> lane 0 sends AA then 66, lane 1 sends 55 then 33, followed by a COM idle frame.
REQ-032 SHALL check two words 32'h12345678 and 32'hDEADBEEF held valid -> two consecutive DATA frames with no COM between; ready is high once per 16 cycles.
REQ-033 SHALL check reset pulsed low at count 5 of a DATA frame -> lanes 0 on the next edge, then a full SYNC_FRAMES COM preamble restarts.
REQ-034 SHALL check, with PHY_TX_LANE_SKEW_EN defined, data_out_1 equals the non-skew lane-1 stream delayed by 4 cycles, with its first 4 bits after reset equal to 0.
